// File: rtl/normal_word_feeder.sv
// Transmitter for the round_block word interface: reads a normal-polynomial
// word stream from RAM and presents it on the word_valid/word_accepted handshake.
module normal_word_feeder #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DIFF_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIFF_WIDTH-1:0] sparse_diff_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] normal_word_out,
  output logic                  word_valid,
  output logic                  only_add,
  output logic [DIFF_WIDTH-1:0] normal_sparse_diff,
  input  logic                  word_accepted,
  input  logic                  processing_done,
  output logic [ADDR_WIDTH:0]   word_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_WAIT_PROC = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH:0]     num_words_r, num_words_s;
  logic [ADDR_WIDTH-1:0]   base_addr_r, base_addr_s;
  logic [DIFF_WIDTH-1:0]   diff_r, diff_s;
  logic [ADDR_WIDTH:0]     index_r, index_s;
  logic [ADDR_WIDTH:0]     index_inc_s;
  logic                    rd_en_r, rd_en_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    rdata_vld_r;
  logic [WORD_WIDTH-1:0]   word_r, word_s;
  logic                    valid_r, valid_s;
  logic                    only_add_r, only_add_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;

  assign index_inc_s = index_r + IDX_ONE;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s     = state_r;
    num_words_s = num_words_r;
    base_addr_s = base_addr_r;
    diff_s      = diff_r;
    index_s     = index_r;
    rd_en_s     = 1'b0;
    addr_s      = addr_r;
    word_s      = word_r;
    valid_s     = valid_r;
    only_add_s  = only_add_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The done-pulse cycle is still owned by the finished stream.
        if (start && !done_r) begin
          num_words_s = num_words;
          base_addr_s = base_addr;
          diff_s      = sparse_diff_in;
          index_s     = IDX_ZERO;
          busy_s      = 1'b1;
          state_s     = (num_words == IDX_ZERO) ? ST_FINISH : ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_en_s = 1'b1;
        addr_s  = base_addr_r + index_r[ADDR_WIDTH-1:0];
        state_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (rdata_vld_r) begin
          word_s     = mem_rdata;
          valid_s    = 1'b1;
          only_add_s = (index_r == IDX_ZERO);
          state_s    = ST_PRESENT;
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_PRESENT: begin
        if (word_accepted) begin
          valid_s = 1'b0;
          if (index_r == IDX_ZERO) begin
            index_s = index_inc_s;
            state_s = (num_words_r == IDX_ONE) ? ST_FINISH : ST_FETCH;
          end else begin
            state_s = ST_WAIT_PROC;
          end
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_WAIT_PROC: begin
        if (processing_done) begin
          index_s = index_inc_s;
          state_s = (index_inc_s == num_words_r) ? ST_FINISH : ST_FETCH;
        end else begin
          state_s = ST_WAIT_PROC;
        end
      end
      ST_FINISH: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched stream parameters, RAM read pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_words_r <= IDX_ZERO;
      base_addr_r <= {ADDR_WIDTH{1'b0}};
      diff_r      <= {DIFF_WIDTH{1'b0}};
      index_r     <= IDX_ZERO;
      rd_en_r     <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      rdata_vld_r <= 1'b0;
      word_r      <= {WORD_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      only_add_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      num_words_r <= num_words_s;
      base_addr_r <= base_addr_s;
      diff_r      <= diff_s;
      index_r     <= index_s;
      rd_en_r     <= rd_en_s;
      addr_r      <= addr_s;
      rdata_vld_r <= rd_en_r;
      word_r      <= word_s;
      valid_r     <= valid_s;
      only_add_r  <= only_add_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign mem_rd_en          = rd_en_r;
  assign mem_addr           = addr_r;
  assign normal_word_out    = word_r;
  assign word_valid         = valid_r;
  assign only_add           = only_add_r;
  assign normal_sparse_diff = diff_r;
  assign word_index         = index_r;
  assign busy               = busy_r;
  assign done               = done_r;

endmodule

// File: tb/tb_normal_word_feeder.sv
// Bench for normal_word_feeder: RAM model, handshaking consumer, and expected
// stream derived from base/num_words arithmetic.
module tb_normal_word_feeder;
  localparam int WW = 32;
  localparam int AW = 6;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] sparse_diff_in = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata = '0;
  logic [WW-1:0] normal_word_out;
  logic          word_valid;
  logic          only_add;
  logic [DW-1:0] normal_sparse_diff;
  logic          word_accepted = 1'b0;
  logic          processing_done = 1'b0;
  logic [AW:0]   word_index;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_fail = 0;
  logic [WW-1:0] ram [0:63];

  normal_word_feeder #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DIFF_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .base_addr(base_addr), .sparse_diff_in(sparse_diff_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .normal_word_out(normal_word_out), .word_valid(word_valid),
    .only_add(only_add), .normal_sparse_diff(normal_sparse_diff),
    .word_accepted(word_accepted), .processing_done(processing_done),
    .word_index(word_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_word"}, normal_word_out, 0);
    chk({tag, "_valid"}, word_valid, 0);
    chk({tag, "_only_add"}, only_add, 0);
    chk({tag, "_diff"}, normal_sparse_diff, 0);
    chk({tag, "_index"}, word_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_stream(input int base, input int n, input int diff, input int acc_dly,
                            input int proc_dly, input bit noise, input bit restart, input bit rst_mid);
    int cyc, widx, vcnt, pd, done_cyc, first_valid_cyc, last_evt;
    bit acc_prev, finished;
    logic [WW-1:0] held;
    int addr_q[$];
    widx = 0; vcnt = 0; pd = -1; done_cyc = -1; first_valid_cyc = -1; last_evt = 0;
    acc_prev = 0; finished = 0; held = '0;
    @(negedge clk);
    start = 1'b1; num_words = n[AW:0]; base_addr = base[AW-1:0]; sparse_diff_in = diff[DW-1:0];
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    chk("diff_latched", normal_sparse_diff, diff[DW-1:0]);
    while (!finished && cyc < 3000) begin
      word_accepted = 1'b0; processing_done = 1'b0; start = 1'b0;
      if (done) begin done_cyc = cyc; finished = 1; end
      if (mem_rd_en) addr_q.push_back(int'(mem_addr));
      if (acc_prev) begin
        chk("valid_drop", word_valid, 0);
        acc_prev = 0; vcnt = 0; widx++;
        if (widx > 1) pd = proc_dly;
        if (rst_mid && widx == 2) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk_all_zero("rst_mid");
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_no_read", mem_rd_en, 0);
            chk("rst_no_valid", word_valid, 0);
          end
          finished = 1;
          break;
        end
      end
      if (word_valid) begin
        if (vcnt == 0) begin
          if (widx == 0) first_valid_cyc = cyc;
          chk("word", normal_word_out, ram[(base + widx) % 64]);
          chk("only_add", only_add, (widx == 0));
          chk("diff_hold", normal_sparse_diff, diff[DW-1:0]);
          held = normal_word_out;
        end else begin
          chk("word_stable", normal_word_out, held);
        end
        vcnt++;
        if (vcnt > acc_dly) begin word_accepted = 1'b1; acc_prev = 1; last_evt = cyc; end
        if (noise) processing_done = 1'b1;
      end else if (noise) begin
        word_accepted = 1'b1;
      end
      if (pd == 0) begin processing_done = 1'b1; last_evt = cyc; pd = -1; end
      else if (pd > 0) pd--;
      if (restart && cyc == 3) begin
        start = 1'b1; num_words = '0; base_addr = base_addr + 6'd5; sparse_diff_in = ~sparse_diff_in;
      end
      @(negedge clk);
      cyc++;
    end
    word_accepted = 1'b0; processing_done = 1'b0; start = 1'b0;
    if (!finished) begin
      chk("timeout", 0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else if (!rst_mid) begin
      chk("done_single", done, 0);
      chk("busy_clear", busy, 0);
      chk("valid_low", word_valid, 0);
      chk("words_sent", widx, n);
      chk("rd_count", addr_q.size(), n);
      for (int i = 0; i < addr_q.size() && i < n; i++)
        chk("rd_addr", addr_q[i], (base + i) % 64);
      chk("diff_after", normal_sparse_diff, diff[DW-1:0]);
      if (n == 0) begin
        chk("done_latency", done_cyc, 2);
        chk("no_valid", first_valid_cyc, -1);
      end else begin
        chk("valid_latency", first_valid_cyc, 4);
        chk("done_after_last", done_cyc, last_evt + 2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[0] = 32'hF601589C;
    ram[1] = 32'h33FACE1B;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    run_stream(0, 2, 6, 1, 3, 1'b0, 1'b0, 1'b0);
    run_stream(0, 2, 9, 5, 2, 1'b1, 1'b0, 1'b0);
    run_stream(0, 0, 3, 0, 1, 1'b0, 1'b0, 1'b0);
    run_stream(0, 1, 4, 2, 1, 1'b1, 1'b0, 1'b0);
    run_stream(62, 4, 17, 0, 1, 1'b0, 1'b0, 1'b0);
    run_stream(10, 3, 33, 1, 2, 1'b0, 1'b1, 1'b0);
    run_stream(20, 4, 45, 1, 4, 1'b0, 1'b0, 1'b1);
    run_stream(0, 2, 6, 1, 3, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++)
      run_stream($urandom_range(0, 63), $urandom_range(0, 9), $urandom_range(0, 63),
                 $urandom_range(0, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
    run_stream(50, 70, 21, 0, 1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
